spiral_unroll: RTL and testbench

- Downstream inverse of the spiral traversal stage.
- Accepts an m x n matrix streamed in clockwise spiral order and buffers it in a register array.
- Re-emits the matrix in row-major (raster) order.
- Sits on the output side of the spiral stage: its valid/rdy input connects directly to that stage's data_out/data_out_valid/data_out_rdy. Used for loop-back checking and raster-order consumers.

---
 rtl/spiral_unroll.sv | 186 ++++++++++++++++++
 tb/tb_spiral_unroll.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spiral_unroll.sv
// spiral_unroll: buffers an m x n matrix that arrives in clockwise spiral
// order and re-emits it in row-major order.
//   clk, rstn              : clock, synchronous active-low reset
//   row, col               : matrix shape, sampled on the first beat
//   data_in / _valid / _rdy: spiral-order input stream
//   data_out / _valid / _last / _rdy : raster-order output stream
module spiral_unroll #(
    parameter int DATA_WIDTH = 8,
    parameter int R_WIDTH    = 3,
    parameter int C_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [R_WIDTH-1:0]    row,
    input  logic [C_WIDTH-1:0]    col,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  data_out_last,
    input  logic                  data_out_rdy
);
    localparam int TW   = R_WIDTH + C_WIDTH;
    localparam int ROWS = 1 << R_WIDTH;
    localparam int COLS = 1 << C_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    typedef enum logic [1:0] {DIR_R, DIR_D, DIR_L, DIR_U} dir_t;

    state_t state, state_nxt;
    dir_t   dir, cur_dir, nxt_dir;

    logic [R_WIDTH-1:0] row_reg, wr_r, top, bottom, rd_r;
    logic [C_WIDTH-1:0] col_reg, wr_c, left, right, rd_c;
    logic [R_WIDTH-1:0] cur_r, cur_top, cur_bottom;
    logic [C_WIDTH-1:0] cur_c, cur_left, cur_right;
    logic [R_WIDTH-1:0] nxt_r, nxt_top, nxt_bottom;
    logic [C_WIDTH-1:0] nxt_c, nxt_left, nxt_right;
    logic [TW-1:0]      total, cnt, prod;

    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    logic in_fire, out_fire, zero_dim, wr_en;
    logic fill_done, rd_row_end, out_done;

    assign in_fire  = data_in_valid && data_in_rdy;
    assign out_fire = data_out_valid && data_out_rdy;
    assign prod     = TW'(row) * TW'(col);
    assign zero_dim = (row == '0) || (col == '0);
    assign wr_en    = in_fire && ((state == FILL) ||
                                  (state == IDLE && !zero_dim));

    // The first beat is judged against the live shape, later ones
    // against the latched element count.
    assign fill_done = (state == IDLE) ? (prod == TW'(1))
                                       : (cnt == total - TW'(1));

    assign rd_row_end    = (rd_c == col_reg - C_WIDTH'(1));
    assign out_done      = rd_row_end && (rd_r == row_reg - R_WIDTH'(1));
    assign data_out      = mem[rd_r][rd_c];
    assign data_out_last = data_out_valid && out_done;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_fire && !zero_dim)
                       state_nxt = fill_done ? DRAIN : FILL;
            FILL:  if (in_fire && fill_done) state_nxt = DRAIN;
            DRAIN: if (out_fire && out_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Walker position for the beat being accepted; in IDLE it starts
    // fresh at (0,0) with bounds taken from the live shape inputs.
    always_comb begin
        cur_r      = wr_r;
        cur_c      = wr_c;
        cur_top    = top;
        cur_bottom = bottom;
        cur_left   = left;
        cur_right  = right;
        cur_dir    = dir;
        if (state == IDLE) begin
            cur_r      = '0;
            cur_c      = '0;
            cur_top    = '0;
            cur_bottom = row - R_WIDTH'(1);
            cur_left   = '0;
            cur_right  = col - C_WIDTH'(1);
            cur_dir    = DIR_R;
        end
        nxt_r      = cur_r;
        nxt_c      = cur_c;
        nxt_top    = cur_top;
        nxt_bottom = cur_bottom;
        nxt_left   = cur_left;
        nxt_right  = cur_right;
        nxt_dir    = cur_dir;
        unique case (cur_dir)
            DIR_R:
                if (cur_c < cur_right) nxt_c = cur_c + C_WIDTH'(1);
                else begin
                    nxt_top = cur_top + R_WIDTH'(1);
                    nxt_r   = cur_r + R_WIDTH'(1);
                    nxt_dir = DIR_D;
                end
            DIR_D:
                if (cur_r < cur_bottom) nxt_r = cur_r + R_WIDTH'(1);
                else begin
                    nxt_right = cur_right - C_WIDTH'(1);
                    nxt_c     = cur_c - C_WIDTH'(1);
                    nxt_dir   = DIR_L;
                end
            DIR_L:
                if (cur_c > cur_left) nxt_c = cur_c - C_WIDTH'(1);
                else begin
                    nxt_bottom = cur_bottom - R_WIDTH'(1);
                    nxt_r      = cur_r - R_WIDTH'(1);
                    nxt_dir    = DIR_U;
                end
            DIR_U:
                if (cur_r > cur_top) nxt_r = cur_r - R_WIDTH'(1);
                else begin
                    nxt_left = cur_left + C_WIDTH'(1);
                    nxt_c    = cur_c + C_WIDTH'(1);
                    nxt_dir  = DIR_R;
                end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            data_in_rdy    <= 1'b0;
            data_out_valid <= 1'b0;
            row_reg        <= '0;
            col_reg        <= '0;
            total          <= '0;
            cnt            <= '0;
            wr_r           <= '0;
            wr_c           <= '0;
            top            <= '0;
            bottom         <= '0;
            left           <= '0;
            right          <= '0;
            dir            <= DIR_R;
            rd_r           <= '0;
            rd_c           <= '0;
        end else begin
            state          <= state_nxt;
            data_in_rdy    <= (state_nxt != DRAIN);
            data_out_valid <= (state_nxt == DRAIN);
            if (wr_en) begin
                wr_r   <= nxt_r;
                wr_c   <= nxt_c;
                top    <= nxt_top;
                bottom <= nxt_bottom;
                left   <= nxt_left;
                right  <= nxt_right;
                dir    <= nxt_dir;
                if (state == IDLE) begin
                    row_reg <= row;
                    col_reg <= col;
                    total   <= prod;
                    cnt     <= TW'(1);
                end else begin
                    cnt <= cnt + TW'(1);
                end
            end
            if (out_fire) begin
                if (rd_row_end) begin
                    rd_c <= '0;
                    rd_r <= out_done ? '0 : rd_r + R_WIDTH'(1);
                end else begin
                    rd_c <= rd_c + C_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[cur_r][cur_c] <= data_in;
    end
endmodule

// File: tb/tb_spiral_unroll.sv
// Randomized bench for spiral_unroll: feeds spiral-ordered matrices and
// expects the raster-ordered originals back.
module tb_spiral_unroll;
    localparam int DW = 8;
    localparam int RW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_rdy;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_last;
    logic          data_out_rdy;

    always #5 clk = ~clk;

    spiral_unroll #(.DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .row           (row),
        .col           (col),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_rdy   (data_in_rdy),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_last (data_out_last),
        .data_out_rdy  (data_out_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int raster[$];
    int spiral[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: raster matrix plus its clockwise spiral traversal,
    // built layer by layer.
    task automatic make_matrix(input int m, input int n, input bit rnd,
                               input int base);
        int t, b, l, r;
        raster.delete();
        spiral.delete();
        for (int i = 0; i < m * n; i++)
            raster.push_back(rnd ? int'($urandom_range(0, 255))
                                 : ((base + i) & 255));
        t = 0; b = m - 1; l = 0; r = n - 1;
        while (t <= b && l <= r) begin
            for (int c = l; c <= r; c++) spiral.push_back(raster[t*n+c]);
            t++;
            for (int rr = t; rr <= b; rr++) spiral.push_back(raster[rr*n+r]);
            r--;
            if (t <= b) begin
                for (int c = r; c >= l; c--) spiral.push_back(raster[b*n+c]);
                b--;
            end
            if (l <= r) begin
                for (int rr = b; rr >= t; rr--) spiral.push_back(raster[rr*n+l]);
                l++;
            end
        end
    endtask

    task automatic run_matrix(input int m, input int n, input bit rnd,
                              input int base, input int gap_pct,
                              input int stall_pct, input int abort_at);
        int idx, k, guard, len;
        bit stalled;
        logic [31:0] prev;
        make_matrix(m, n, rnd, base);
        len = m * n;
        idx = 0;
        guard = 0;
        while (idx < len) begin
            @(negedge clk);
            check("fill_valid_low", 32'(data_out_valid), 32'd0);
            if (guard++ > 5000) begin
                check("fill_timeout", 32'd0, 32'd1);
                data_in_valid = 1'b0;
                return;
            end
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                data_in_valid = 1'b0;
            end else begin
                data_in_valid = 1'b1;
                data_in = DW'(spiral[idx]);
            end
            row = (idx == 0) ? RW'(m) : RW'($urandom);
            col = (idx == 0) ? CW'(n) : CW'($urandom);
            data_out_rdy = 1'($urandom_range(0, 1));
            if (data_in_valid && data_in_rdy) idx++;
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        check("first_out_latency", 32'(data_out_valid), 32'd1);
        k = 0;
        guard = 0;
        stalled = 1'b0;
        prev = '0;
        while (k < len) begin
            if (k == abort_at) begin
                rstn = 1'b0;
                data_out_rdy = 1'b0;
                @(negedge clk);
                check("abort_valid", 32'(data_out_valid), 32'd0);
                check("abort_rdy", 32'(data_in_rdy), 32'd0);
                check("abort_last", 32'(data_out_last), 32'd0);
                rstn = 1'b1;
                @(negedge clk);
                check("abort_rdy_back", 32'(data_in_rdy), 32'd1);
                check("abort_valid2", 32'(data_out_valid), 32'd0);
                return;
            end
            if (guard++ > 5000) begin
                check("drain_timeout", 32'd0, 32'd1);
                return;
            end
            check("drain_valid", 32'(data_out_valid), 32'd1);
            check("drain_rdy_low", 32'(data_in_rdy), 32'd0);
            if (stalled)
                check("stall_hold", 32'({data_out_last, data_out}), prev);
            data_out_rdy = (int'($urandom_range(0, 99)) >= stall_pct);
            if (data_out_valid && data_out_rdy) begin
                check("data", 32'(data_out), 32'(raster[k]));
                check("last", 32'(data_out_last), 32'(k == len - 1));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev = 32'({data_out_last, data_out});
            end
            @(negedge clk);
        end
        check("post_valid", 32'(data_out_valid), 32'd0);
        check("post_last", 32'(data_out_last), 32'd0);
        check("post_rdy", 32'(data_in_rdy), 32'd1);
    endtask

    task automatic zero_beat(input int m, input int n);
        @(negedge clk);
        row = RW'(m);
        col = CW'(n);
        data_in = 8'd77;
        data_in_valid = 1'b1;
        check("zero_rdy", 32'(data_in_rdy), 32'd1);
        @(negedge clk);
        data_in_valid = 1'b0;
        check("zero_no_valid", 32'(data_out_valid), 32'd0);
        check("zero_still_rdy", 32'(data_in_rdy), 32'd1);
    endtask

    initial begin
        rstn = 1'b0;
        row = '0;
        col = '0;
        data_in = '0;
        data_in_valid = 1'b0;
        data_out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(data_in_rdy), 32'd0);
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_last", 32'(data_out_last), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 32'(data_in_rdy), 32'd1);
        check("valid_after_rst", 32'(data_out_valid), 32'd0);

        run_matrix(3, 3, 1'b0, 1, 0, 0, -1);
        run_matrix(3, 4, 1'b0, 1, 0, 0, -1);
        run_matrix(1, 5, 1'b0, 1, 0, 0, -1);
        run_matrix(5, 1, 1'b0, 1, 0, 0, -1);
        run_matrix(1, 1, 1'b0, 42, 0, 0, -1);
        run_matrix(7, 7, 1'b1, 0, 30, 50, -1);
        run_matrix(3, 3, 1'b0, 1, 0, 0, 4);
        run_matrix(2, 2, 1'b0, 1, 0, 0, -1);
        zero_beat(0, 3);
        zero_beat(4, 0);
        run_matrix(2, 2, 1'b0, 1, 0, 0, -1);
        for (int i = 0; i < 10; i++)
            run_matrix(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)),
                       1'b1, 0, 20, 30, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
